// File: rtl/bpe_merge_engine.sv
// bpe_merge_engine: byte-pair-encoding merge datapath.
// A token sequence is loaded into ping-pong buffer A. Each entry of an
// external synchronous rule table is then applied in priority order, one
// rule per pass. A pass copies the source buffer into the destination buffer
// and replaces every greedy, non-overlapping (left,right) pair with the
// merged token. Once all rules have run, the final sequence streams out.
//
// Handshake: a beat transfers on a rising edge where valid, ready and cs are
// all high. Dropping cs freezes every register, so the engine simply resumes
// where it stopped.
module bpe_merge_engine #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 4,
   parameter int RULE_ADDR_WIDTH = 4,
   parameter int NUM_RULES       = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cs,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         in_last,
   output logic [RULE_ADDR_WIDTH-1:0]   rule_addr,
   input  logic [3*DATA_WIDTH:0]        rule_rdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_last,
   output logic [ADDR_WIDTH:0]          merge_count,
   output logic                         overflow,
   output logic                         done
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int LW    = ADDR_WIDTH + 1;
   localparam int RW    = 3*DATA_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FETCH = 3'd2,
      S_WAIT  = 3'd3,
      S_SCAN  = 3'd4,
      S_NEXT  = 3'd5,
      S_DRAIN = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Ping-pong token buffers; r_src_sel=0 means A is the source.
   logic [DATA_WIDTH-1:0] r_buf_a [DEPTH];
   logic [DATA_WIDTH-1:0] r_buf_b [DEPTH];
   logic                  r_src_sel;

   logic [LW-1:0]              r_len;
   logic [LW-1:0]              r_i;
   logic [LW-1:0]              r_j;
   logic [LW-1:0]              r_k;
   logic [RULE_ADDR_WIDTH-1:0] r_rule_idx;
   logic [RW-2:0]              r_rule;
   logic [LW-1:0]              r_merge_cnt;
   logic                       r_overflow;

   logic                  w_accepting;
   logic                  w_in_fire;
   logic                  w_out_fire;
   logic                  w_last_rule;
   logic                  w_rule_skip;
   logic [DATA_WIDTH-1:0] w_rule_left;
   logic [DATA_WIDTH-1:0] w_rule_right;
   logic [DATA_WIDTH-1:0] w_rule_merged;
   logic [ADDR_WIDTH-1:0] w_i_idx;
   logic [ADDR_WIDTH-1:0] w_i1_idx;
   logic [ADDR_WIDTH-1:0] w_k_idx;
   logic [DATA_WIDTH-1:0] w_src_i;
   logic [DATA_WIDTH-1:0] w_src_i1;
   logic                  w_match;
   logic [LW-1:0]         w_i_nxt;
   logic [DATA_WIDTH-1:0] w_scan_tok;
   logic                  w_scan_end;
   logic [DATA_WIDTH-1:0] w_drain_tok;
   logic                  w_drain_last;

   // Handshake qualifiers.
   assign w_accepting = cs && ((r_state == S_IDLE) || (r_state == S_LOAD));
   assign in_ready    = w_accepting;
   assign w_in_fire   = w_accepting && in_valid;
   assign w_out_fire  = cs && out_ready && (r_state == S_DRAIN);

   // Rule bookkeeping. The table is read with r_rule_idx as address; the
   // word returned during WAIT decides whether the rule is skipped.
   assign rule_addr     = r_rule_idx;
   assign w_last_rule   = (r_rule_idx == RULE_ADDR_WIDTH'(NUM_RULES - 1));
   assign w_rule_skip   = !rule_rdata[RW-1] || (r_len < LW'(2));
   assign w_rule_left   = r_rule[3*DATA_WIDTH-1:2*DATA_WIDTH];
   assign w_rule_right  = r_rule[2*DATA_WIDTH-1:DATA_WIDTH];
   assign w_rule_merged = r_rule[DATA_WIDTH-1:0];

   // Scan datapath: compare src[i], src[i+1] against the latched rule.
   // The i+1 index may wrap when i is the last slot; the i<len-1 guard
   // masks that case out of the match.
   assign w_i_idx    = r_i[ADDR_WIDTH-1:0];
   assign w_i1_idx   = w_i_idx + ADDR_WIDTH'(1);
   assign w_src_i    = r_src_sel ? r_buf_b[w_i_idx]  : r_buf_a[w_i_idx];
   assign w_src_i1   = r_src_sel ? r_buf_b[w_i1_idx] : r_buf_a[w_i1_idx];
   assign w_match    = (r_i < (r_len - LW'(1))) &&
                       (w_src_i == w_rule_left) && (w_src_i1 == w_rule_right);
   assign w_i_nxt    = r_i + (w_match ? LW'(2) : LW'(1));
   assign w_scan_tok = w_match ? w_rule_merged : w_src_i;
   assign w_scan_end = (w_i_nxt >= r_len);

   // Drain datapath: out_data follows src[k], k only moves on a handshake.
   assign w_k_idx      = r_k[ADDR_WIDTH-1:0];
   assign w_drain_tok  = r_src_sel ? r_buf_b[w_k_idx] : r_buf_a[w_k_idx];
   assign w_drain_last = (r_k == (r_len - LW'(1)));

   assign merge_count = r_merge_cnt;
   assign overflow    = r_overflow;

   // State register; cs=0 holds the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (cs) begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and stream outputs. A skipped rule goes straight from WAIT
   // to the next FETCH (or to DRAIN), so a skipped rule costs two cycles.
   always_comb begin
      w_state_nxt = r_state;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_in_fire) w_state_nxt = in_last ? S_FETCH : S_LOAD;
         end
         S_LOAD: begin
            if (w_in_fire && in_last) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_rule_skip) w_state_nxt = w_last_rule ? S_DRAIN : S_FETCH;
            else             w_state_nxt = S_SCAN;
         end
         S_SCAN: begin
            if (w_scan_end) w_state_nxt = S_NEXT;
         end
         S_NEXT: begin
            w_state_nxt = w_last_rule ? S_DRAIN : S_FETCH;
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            out_data  = w_drain_tok;
            out_last  = w_drain_last;
            if (w_out_fire && w_drain_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = cs;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Control registers: length, scan/drain indices, rule index, statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len       <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_k         <= '0;
         r_rule_idx  <= '0;
         r_rule      <= '0;
         r_merge_cnt <= '0;
         r_overflow  <= 1'b0;
         r_src_sel   <= 1'b0;
      end else if (cs) begin
         case (r_state)
            S_IDLE: begin
               if (w_in_fire) begin
                  r_len       <= LW'(1);
                  r_overflow  <= 1'b0;
                  r_merge_cnt <= '0;
                  r_src_sel   <= 1'b0;
                  r_rule_idx  <= '0;
               end
            end
            S_LOAD: begin
               if (w_in_fire) begin
                  if (r_len == LW'(DEPTH)) r_overflow <= 1'b1;
                  else                     r_len      <= r_len + LW'(1);
               end
            end
            S_WAIT: begin
               r_rule <= rule_rdata[RW-2:0];
               r_i    <= '0;
               r_j    <= '0;
               if (w_rule_skip) begin
                  if (w_last_rule) r_k        <= '0;
                  else             r_rule_idx <= r_rule_idx + RULE_ADDR_WIDTH'(1);
               end
            end
            S_SCAN: begin
               r_i <= w_i_nxt;
               r_j <= r_j + LW'(1);
               if (w_match && (r_merge_cnt != '1)) r_merge_cnt <= r_merge_cnt + LW'(1);
               if (w_scan_end) begin
                  r_len     <= r_j + LW'(1);
                  r_src_sel <= ~r_src_sel;
               end
            end
            S_NEXT: begin
               if (w_last_rule) r_k        <= '0;
               else             r_rule_idx <= r_rule_idx + RULE_ADDR_WIDTH'(1);
            end
            S_DRAIN: begin
               if (w_out_fire && !w_drain_last) r_k <= r_k + LW'(1);
            end
            S_DONE: begin
               r_rule_idx <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   // Buffer writes: input beats land in A, scan output lands in the
   // non-source buffer. Beats past DEPTH are dropped here.
   always_ff @(posedge clk) begin
      if (cs) begin
         if (w_in_fire && (r_state == S_IDLE)) begin
            r_buf_a[0] <= in_data;
         end else if (w_in_fire && (r_state == S_LOAD) && (r_len < LW'(DEPTH))) begin
            r_buf_a[r_len[ADDR_WIDTH-1:0]] <= in_data;
         end
         if (r_state == S_SCAN) begin
            if (r_src_sel) r_buf_a[r_j[ADDR_WIDTH-1:0]] <= w_scan_tok;
            else           r_buf_b[r_j[ADDR_WIDTH-1:0]] <= w_scan_tok;
         end
      end
   end

endmodule

// File: tb/tb_bpe_merge_engine.sv
// Bench for bpe_merge_engine: directed scenarios plus randomized sequences,
// each compared against a queue-based merge model of the rule semantics.
module tb_bpe_merge_engine;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int RAW   = 4;
   localparam int NR    = 16;
   localparam int DEPTH = 16;
   localparam int RW    = 3*DW + 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           cs = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [DW-1:0]  in_data = '0;
   logic           in_last = 1'b0;
   logic [RAW-1:0] rule_addr;
   logic [RW-1:0]  rule_rdata = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [DW-1:0]  out_data;
   logic           out_last;
   logic [AW:0]    merge_count;
   logic           overflow;
   logic           done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [RW-1:0] rom [NR];
   logic [DW-1:0] in_q[$];
   logic [DW-1:0] exp_q[$];
   int            exp_merges;
   logic          exp_ovf;
   int            exp_lat;

   bpe_merge_engine #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RULE_ADDR_WIDTH(RAW), .NUM_RULES(NR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cs(cs),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .rule_addr(rule_addr), .rule_rdata(rule_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .merge_count(merge_count), .overflow(overflow), .done(done)
   );

   // Clock.
   always #5 clk = ~clk;

   // Synchronous rule table: data one cycle after address.
   always @(posedge clk) rule_rdata <= rom[rule_addr];

   task automatic clear_rules();
      for (int r = 0; r < NR; r++) rom[r] = '0;
   endtask

   task automatic set_rule(input int r, input logic [DW-1:0] l, input logic [DW-1:0] rr,
                           input logic [DW-1:0] m);
      rom[r] = {1'b1, l, rr, m};
   endtask

   // Reference model: truncate to DEPTH, apply each rule greedily left to
   // right on a queue, and total the cycle cost of every rule.
   task automatic model_run();
      logic [DW-1:0] cur[$];
      logic [DW-1:0] nxt[$];
      logic [DW-1:0] l, rr, m;
      int mc;
      int i;
      cur = {};
      exp_merges = 0;
      exp_lat = 0;
      for (int t = 0; t < in_q.size(); t++) if (t < DEPTH) cur.push_back(in_q[t]);
      exp_ovf = (in_q.size() > DEPTH);
      for (int r = 0; r < NR; r++) begin
         if (!rom[r][RW-1] || cur.size() < 2) begin
            exp_lat += 2;
         end else begin
            l  = rom[r][3*DW-1:2*DW];
            rr = rom[r][2*DW-1:DW];
            m  = rom[r][DW-1:0];
            nxt = {};
            mc = 0;
            i = 0;
            while (i < cur.size()) begin
               if (i + 1 < cur.size() && cur[i] == l && cur[i+1] == rr) begin
                  nxt.push_back(m);
                  i += 2;
                  mc++;
               end else begin
                  nxt.push_back(cur[i]);
                  i += 1;
               end
            end
            exp_lat += 3 + cur.size() - mc;
            exp_merges += mc;
            cur = nxt;
         end
      end
      if (exp_merges > 31) exp_merges = 31;
      exp_q = cur;
   endtask

   // Driver: one beat per cycle, in_ready must be high for every beat.
   task automatic drive_inputs(input string name);
      for (int i = 0; i < in_q.size(); i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = in_q[i];
         in_last  = (i == in_q.size() - 1);
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready beat %0d: got %b want 1", name, i, in_ready);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   // Collector / scoreboard: latency to first out_valid, drained tokens,
   // out_last placement, stall stability, done pulse and statistics.
   task automatic collect(input string name, input int ready_mode, input int cs_gap);
      int            wait_cnt;
      int            beats;
      int            pat;
      logic          rdy;
      logic          stall;
      logic          fin;
      logic [DW-1:0] held;
      logic [DW-1:0] want;
      logic [3:0]    pattern;
      pattern  = 4'b1001;
      wait_cnt = 0;
      beats    = 0;
      pat      = 0;
      stall    = 1'b0;
      fin      = 1'b0;
      held     = '0;
      out_ready = 1'b0;
      while (out_valid !== 1'b1 && wait_cnt < 2000) begin
         @(negedge clk);
         wait_cnt++;
         if (cs_gap > 0 && wait_cnt == cs_gap) cs = 1'b0;
         if (cs_gap > 0 && wait_cnt == cs_gap + 5) cs = 1'b1;
      end
      cs = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s out_valid timeout: got %b want 1", name, out_valid);
         return;
      end
      if (wait_cnt != exp_lat + ((cs_gap > 0) ? 5 : 0)) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, wait_cnt,
                  exp_lat + ((cs_gap > 0) ? 5 : 0));
      end
      while (!fin && beats < 500) begin
         if (stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               n_fail++;
               $display("FAIL %s stall hold: got v=%b d=%0d want v=1 d=%0d", name,
                        out_valid, out_data, held);
            end
         end
         case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = pattern[3 - (pat % 4)];
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         pat++;
         out_ready = rdy;
         if (out_valid === 1'b1 && rdy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra token: got %0d want none", name, out_data);
               fin = 1'b1;
            end else begin
               want = exp_q.pop_front();
               if (out_data !== want || out_last !== (exp_q.size() == 0)) begin
                  n_fail++;
                  $display("FAIL %s token: got %0d last=%b want %0d last=%b", name,
                           out_data, out_last, want, (exp_q.size() == 0));
               end
               if (out_last === 1'b1) fin = 1'b1;
            end
            stall = 1'b0;
         end else begin
            stall = (out_valid === 1'b1);
            held  = out_data;
         end
         @(negedge clk);
         beats++;
      end
      out_ready = 1'b0;
      n_checks++;
      if (!fin || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s drain end: got fin=%b left=%0d want fin=1 left=0", name, fin,
                  exp_q.size());
      end
      n_checks++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done pulse: got done=%b v=%b want done=1 v=0", name, done, out_valid);
      end
      n_checks++;
      if (merge_count !== 5'(exp_merges) || overflow !== exp_ovf) begin
         n_fail++;
         $display("FAIL %s stats: got merges=%0d ovf=%b want merges=%0d ovf=%b", name,
                  merge_count, overflow, exp_merges, exp_ovf);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s after done: got done=%b rdy=%b want done=0 rdy=1", name, done, in_ready);
      end
   endtask

   task automatic run_case(input string name, input int ready_mode, input int cs_gap);
      model_run();
      drive_inputs(name);
      collect(name, ready_mode, cs_gap);
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || rule_addr !== '0 ||
          merge_count !== '0 || overflow !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s outputs: got v=%b d=%0d l=%b ra=%0d mc=%0d ov=%b dn=%b want all 0",
                  name, out_valid, out_data, out_last, rule_addr, merge_count, overflow, done);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready: got %b want 1", name, in_ready);
      end
   endtask

   task automatic test_reset();
      check_reset_outputs("reset");
   endtask

   task automatic test_basic_merge();
      clear_rules();
      set_rule(0, 8'd1, 8'd2, 8'd10);
      set_rule(1, 8'd10, 8'd3, 8'd11);
      in_q = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2};
      run_case("basic_merge", 0, 0);
   endtask

   task automatic test_no_overlap();
      clear_rules();
      set_rule(0, 8'd5, 8'd5, 8'd7);
      in_q = '{8'd5, 8'd5, 8'd5};
      run_case("overlap3", 0, 0);
      in_q = '{8'd5, 8'd5, 8'd5, 8'd5};
      run_case("overlap4", 0, 0);
   endtask

   task automatic test_overflow();
      clear_rules();
      in_q = {};
      for (int i = 0; i < 18; i++) in_q.push_back(DW'(i));
      run_case("overflow", 0, 0);
   endtask

   task automatic test_single_token();
      clear_rules();
      set_rule(0, 8'd9, 8'd9, 8'd1);
      set_rule(3, 8'd9, 8'd0, 8'd2);
      in_q = '{8'd9};
      run_case("single", 0, 0);
   endtask

   task automatic test_backpressure();
      clear_rules();
      set_rule(0, 8'd1, 8'd2, 8'd3);
      in_q = '{8'd4, 8'd1, 8'd2, 8'd5, 8'd6, 8'd1, 8'd2, 8'd7};
      run_case("backpressure", 1, 0);
   endtask

   task automatic test_cs_freeze();
      clear_rules();
      set_rule(0, 8'd1, 8'd2, 8'd9);
      set_rule(2, 8'd9, 8'd9, 8'd8);
      in_q = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6};
      run_case("cs_ref", 0, 0);
      run_case("cs_freeze", 0, 3);
   endtask

   task automatic test_reset_mid_scan();
      clear_rules();
      set_rule(1, 8'd1, 8'd2, 8'd20);
      in_q = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
      drive_inputs("rst_mid");
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      set_rule(0, 8'd2, 8'd1, 8'd30);
      in_q = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd3};
      run_case("after_rst", 0, 0);
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 8; it++) begin
         clear_rules();
         for (int r = 0; r < NR; r++) begin
            if ($urandom_range(0, 1) == 1)
               set_rule(r, DW'($urandom_range(1, 4)), DW'($urandom_range(1, 4)),
                        DW'($urandom_range(1, 6)));
         end
         n = $urandom_range(1, 19);
         in_q = {};
         for (int i = 0; i < n; i++) in_q.push_back(DW'($urandom_range(1, 4)));
         run_case("random", 2, 0);
      end
   endtask

   task automatic test_back_to_back();
      clear_rules();
      set_rule(0, 8'd3, 8'd3, 8'd6);
      in_q = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
      run_case("b2b_a", 0, 0);
      in_q = '{8'd6, 8'd3, 8'd3};
      run_case("b2b_b", 2, 0);
   endtask

   initial begin
      clear_rules();
      cs = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_basic_merge();
      test_no_overlap();
      test_overflow();
      test_single_token();
      test_backpressure();
      test_cs_freeze();
      test_reset_mid_scan();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
